mitm_bus_driver: RTL and testbench
==================================

Name: mitm_bus_driver

Overview:
Transmit-side counterpart to the MITM decision logic. It accepts a data word, a bit count and a fake/real select from the MITM logic. It then drives the intercepted serial line (e.g. MISO toward the master) MSB-first, clocked by edges of the bus SCK. When fake is deselected it passes the real line through unchanged. It reports completion so the MITM logic can advance its state machine.

Parameters:
MAX_DATA_SIZE, 9, width of the data word; bits are sent from bit MAX_DATA_SIZE-1 downward.
DATA_SIZE_WIDTH, $clog2(MAX_DATA_SIZE+1), width of the bit-count fields.
SYNC_STAGES, 2, flip-flop stages used to synchronise bus_sck and bus_cs_n into sys_clk.

Ports:
sys_clk  input  1  system clock; the only clock in the block.
rst_n  input  1  asynchronous, active-low reset.
bus_sck  input  1  raw serial clock from the bus master; asynchronous to sys_clk.
bus_cs_n  input  1  raw chip select; active low; asynchronous to sys_clk.
real_in  input  1  real line from the genuine device.
load  input  1  one-cycle strobe that latches fake_data, data_size and fake_select.
fake_data  input  MAX_DATA_SIZE  word to transmit, MSB-aligned.
data_size  input  DATA_SIZE_WIDTH  number of bus bits this transfer covers.
fake_select  input  1  1 = drive fake bits, 0 = pass real_in through.
bus_out  output  1  line driven toward the master.
busy  output  1  a transfer is in progress.
done  output  1  one-cycle pulse when a transfer ends.
aborted  output  1  valid with done; 1 = transfer ended by CS deassertion.
bits_left  output  DATA_SIZE_WIDTH  number of bits remaining in the current transfer.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; shift_reg 0; bits_left 0; sel_q 0; busy 0; done 0; aborted 0; synchroniser flops at the idle levels (sck 0, cs_n 1). bus_out = real_in.
- Edge detection: bus_sck and bus_cs_n each pass through SYNC_STAGES flops plus one history flop.
  - sck_rise, sck_fall and cs_rise are single-cycle pulses.
  - Latency from a bus edge to the block's response is SYNC_STAGES+1 sys_clk cycles.
  - sys_clk must be at least 8x the SCK frequency.
- bus_out is a combinational mux: (busy & sel_q) ? shift_reg[MAX_DATA_SIZE-1] : real_in. No glitch is permitted on the real path.
- State machine:
  - IDLE, on load:
    - Latch shift_reg = fake_data and sel_q = fake_select.
    - bits_left = min(data_size, MAX_DATA_SIZE); values above MAX_DATA_SIZE clamp.
    - If the clamped size is 0: go to FINISH with aborted=0 and no bus effect.
    - Otherwise: go to ACTIVE and set busy=1. The first bit is visible on bus_out in the cycle after load.
  - ACTIVE:
    - On sck_rise (master samples): bits_left decrements. If it reaches 0, go to FINISH with aborted=0.
    - On sck_fall, with bits_left > 0: shift_reg <<= 1, zero filled.
    - On cs_rise: go to FINISH with aborted=1, regardless of bits_left. If cs_rise and sck_rise occur in the same cycle, the abort wins.
    - load is ignored while in ACTIVE.
  - FINISH: for one cycle, busy=0, done=1, aborted as set, sel_q cleared. Then go to IDLE. The next load is accepted in the cycle after FINISH.
- done is never asserted outside FINISH; aborted is 0 whenever done is 0.
- Any undefined state encoding goes to IDLE and clears all outputs.
- Reset mid-transfer: bus_out falls back to real_in immediately (asynchronously). No done pulse is generated.

Decomposition:
- Shared package/include: MAX_DATA_SIZE, DATA_SIZE_WIDTH and the state encodings. The MITM logic and the buffer blocks use the same constants.
- Sub-module sync_edge_detect: parameters SYNC_STAGES and RESET_LEVEL; outputs the level, rise and fall signals. It is instantiated twice (SCK and CS).

Test Plan:
- Fake byte: load fake_data=9'h048, data_size=8, fake_select=1, then 8 SCK cycles with cs_n low -> bus_out sampled on the rising edges reads 0,0,1,0,0,1,0,0 (0x24). done=1 and aborted=0 appear exactly one cycle after the 8th synchronised rise; bus_out = real_in afterwards.
- Passthrough: load fake_select=0, data_size=3, toggle real_in randomly -> bus_out equals real_in on every cycle; done after the 3rd rise.
- Abort: 9-bit fake transfer, raise cs_n after 4 rises -> done=1 and aborted=1, bits_left holds 5 at that time, and bus_out reverts to real_in.
- Zero and oversize: load with data_size=0 -> done on the next cycle and bus_out never leaves real_in. load with data_size=15 -> clamps to 9, done after 9 rises.
- Load while busy: a second load mid-transfer with fake_data=9'h1FF -> ignored; the original bit stream is unchanged.
- Reset mid-transfer: pull rst_n low after 3 bits -> bus_out = real_in in the same cycle, busy=0, and no done pulse. A new transfer after reset completes normally.

Source files
------------

// File: rtl/mitm_bus_driver_pkg.sv
// Shared constants and state encodings for the MITM transmit path.
// The MITM decision logic and the buffer blocks import the same values.
package mitm_bus_driver_pkg;

    // Width of the data word; bits leave the block from bit MAX-1 downward.
    localparam int MBD_MAX_DATA_SIZE   = 9;
    // Width of the bit-count fields (must hold 0..MAX inclusive).
    localparam int MBD_DATA_SIZE_WIDTH = $clog2(MBD_MAX_DATA_SIZE + 1);
    // Flip-flop stages used to bring bus_sck / bus_cs_n into sys_clk.
    localparam int MBD_SYNC_STAGES     = 2;

    // Transfer state machine encodings.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_FINISH = 2'b10
    } mbd_state_e;

endpackage : mitm_bus_driver_pkg

// File: rtl/mitm_bus_driver_sync_edge_detect.sv
// Synchroniser chain plus history flop for one asynchronous bus signal.
// Produces the synchronised level and single-cycle rise/fall pulses.
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level_s,
    output logic rise_s,
    output logic fall_s
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;

    // Shift the raw input through the synchroniser and remember the previous level.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{RESET_LEVEL}};
            hist_r <= RESET_LEVEL;
        end else begin
            sync_r[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign level_s = sync_r[SYNC_STAGES-1];
    assign rise_s  = sync_r[SYNC_STAGES-1] & ~hist_r;
    assign fall_s  = ~sync_r[SYNC_STAGES-1] & hist_r;

endmodule : sync_edge_detect

// File: rtl/mitm_bus_driver.sv
// Transmit side of the MITM path: drives the intercepted serial line MSB-first
// from a latched word on synchronised SCK edges, or passes the real line through.
// Reports completion (normal or CS abort) with a one-cycle done pulse.
module mitm_bus_driver
    import mitm_bus_driver_pkg::*;
#(
    parameter int MAX_DATA_SIZE   = MBD_MAX_DATA_SIZE,
    parameter int DATA_SIZE_WIDTH = $clog2(MAX_DATA_SIZE + 1),
    parameter int SYNC_STAGES     = MBD_SYNC_STAGES
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       bus_sck,
    input  logic                       bus_cs_n,
    input  logic                       real_in,
    input  logic                       load,
    input  logic [MAX_DATA_SIZE-1:0]   fake_data,
    input  logic [DATA_SIZE_WIDTH-1:0] data_size,
    input  logic                       fake_select,
    output logic                       bus_out,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [DATA_SIZE_WIDTH-1:0] bits_left
);

    localparam logic [DATA_SIZE_WIDTH-1:0] MAX_SIZE_C = DATA_SIZE_WIDTH'(MAX_DATA_SIZE);
    localparam logic [DATA_SIZE_WIDTH-1:0] ZERO_C     = {DATA_SIZE_WIDTH{1'b0}};
    localparam logic [DATA_SIZE_WIDTH-1:0] ONE_C      = DATA_SIZE_WIDTH'(1);
    localparam logic [MAX_DATA_SIZE-1:0]   WORD_ZERO_C = {MAX_DATA_SIZE{1'b0}};

    // Synchronised bus events
    logic sck_level_s;
    logic sck_rise_s;
    logic sck_fall_s;
    logic cs_level_s;
    logic cs_rise_s;
    logic cs_fall_s;
    logic unused_ok_s;

    // State and datapath registers
    mbd_state_e                 state_r;
    logic [MAX_DATA_SIZE-1:0]   shift_r;
    logic [DATA_SIZE_WIDTH-1:0] bits_left_r;
    logic                       sel_r;
    logic                       busy_r;
    logic                       done_r;
    logic                       aborted_r;

    // Next-state values
    mbd_state_e                 state_nxt_s;
    logic [MAX_DATA_SIZE-1:0]   shift_nxt_s;
    logic [DATA_SIZE_WIDTH-1:0] bits_nxt_s;
    logic                       sel_nxt_s;
    logic                       busy_nxt_s;
    logic                       done_nxt_s;
    logic                       aborted_nxt_s;
    logic [DATA_SIZE_WIDTH-1:0] size_clamped_s;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_LEVEL (1'b0)
    ) u_sck_sync (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .async_in (bus_sck),
        .level_s  (sck_level_s),
        .rise_s   (sck_rise_s),
        .fall_s   (sck_fall_s)
    );

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_LEVEL (1'b1)
    ) u_cs_sync (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .async_in (bus_cs_n),
        .level_s  (cs_level_s),
        .rise_s   (cs_rise_s),
        .fall_s   (cs_fall_s)
    );

    // Levels and the CS falling edge carry no meaning for the transmit path.
    assign unused_ok_s = sck_level_s ^ cs_level_s ^ cs_fall_s;

    // Clamp the requested bit count to the width of the data word.
    always_comb begin
        size_clamped_s = data_size;
        if (data_size > MAX_SIZE_C) begin
            size_clamped_s = MAX_SIZE_C;
        end else begin
            size_clamped_s = data_size;
        end
    end

    // Next-state and datapath decisions; done/aborted default low so they pulse.
    always_comb begin
        state_nxt_s   = state_r;
        shift_nxt_s   = shift_r;
        bits_nxt_s    = bits_left_r;
        sel_nxt_s     = sel_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        aborted_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
                sel_nxt_s  = 1'b0;
                if (load) begin
                    shift_nxt_s = fake_data;
                    bits_nxt_s  = size_clamped_s;
                    if (size_clamped_s == ZERO_C) begin
                        // Empty transfer: report completion without touching the bus.
                        state_nxt_s = ST_FINISH;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_ACTIVE;
                        busy_nxt_s  = 1'b1;
                        sel_nxt_s   = fake_select;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_s) begin
                    // Master ended the frame early; abort beats a coincident SCK rise.
                    state_nxt_s   = ST_FINISH;
                    busy_nxt_s    = 1'b0;
                    sel_nxt_s     = 1'b0;
                    done_nxt_s    = 1'b1;
                    aborted_nxt_s = 1'b1;
                end else if (sck_rise_s && (bits_left_r != ZERO_C)) begin
                    // Master has sampled the current bit.
                    bits_nxt_s = bits_left_r - ONE_C;
                    if (bits_left_r == ONE_C) begin
                        state_nxt_s = ST_FINISH;
                        busy_nxt_s  = 1'b0;
                        sel_nxt_s   = 1'b0;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_ACTIVE;
                    end
                end else if (sck_fall_s && (bits_left_r != ZERO_C)) begin
                    // Present the next bit while SCK is low.
                    shift_nxt_s = {shift_r[MAX_DATA_SIZE-2:0], 1'b0};
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
                sel_nxt_s   = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                shift_nxt_s = WORD_ZERO_C;
                bits_nxt_s  = ZERO_C;
                sel_nxt_s   = 1'b0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r     <= WORD_ZERO_C;
            bits_left_r <= ZERO_C;
            sel_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
        end else begin
            shift_r     <= shift_nxt_s;
            bits_left_r <= bits_nxt_s;
            sel_r       <= sel_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            aborted_r   <= aborted_nxt_s;
        end
    end

    // Select comes only from flops, so the real path cannot glitch; reset
    // clears busy_r asynchronously and returns the line to real_in at once.
    assign bus_out   = (busy_r & sel_r) ? shift_r[MAX_DATA_SIZE-1] : real_in;
    assign busy      = busy_r;
    assign done      = done_r;
    assign aborted   = aborted_r;
    assign bits_left = bits_left_r;

endmodule : mitm_bus_driver

// File: tb/tb_mitm_bus_driver.sv
// Directed + randomized bench for mitm_bus_driver with a transfer-level model.
module tb_mitm_bus_driver;
    import mitm_bus_driver_pkg::*;

    localparam int W    = MBD_MAX_DATA_SIZE;
    localparam int SW   = MBD_DATA_SIZE_WIDTH;
    localparam int HALF = 8;   // sys_clk cycles per SCK half period
    localparam int LAT  = 3;   // bus edge to response: two sync stages + one

    logic          sys_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bus_sck = 1'b0;
    logic          bus_cs_n = 1'b1;
    logic          real_in = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  fake_data = '0;
    logic [SW-1:0] data_size = '0;
    logic          fake_select = 1'b0;
    logic          bus_out;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [SW-1:0] bits_left;

    int total = 0;
    int bad = 0;

    mitm_bus_driver dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .bus_sck     (bus_sck),
        .bus_cs_n    (bus_cs_n),
        .real_in     (real_in),
        .load        (load),
        .fake_data   (fake_data),
        .data_size   (data_size),
        .fake_select (fake_select),
        .bus_out     (bus_out),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .bits_left   (bits_left)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit the master should see on its idx-th rising edge (MSB first).
    function automatic logic model_bit(input logic [W-1:0] w, input int idx);
        int v;
        v = int'(w);
        return ((v >> (W - 1 - idx)) & 1) == 1;
    endfunction

    // Randomize the real line, then advance to the next sampling point.
    task automatic step();
        real_in = 1'($urandom_range(0, 1));
        @(negedge sys_clk);
    endtask

    // Wait for done after a bus event; returns the number of cycles taken.
    task automatic wait_done(input logic sel, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
            if (!sel) check("pass_wait", 32'(bus_out), 32'(real_in));
        end while (done !== 1'b1 && lat < 20);
    endtask

    // kind: 0 = run to completion, 1 = CS abort after stop_after rises,
    //       2 = reset after stop_after rises.
    task automatic run_transfer(input logic [W-1:0] word, input int size, input logic sel,
                                input int kind, input int stop_after, input int mid_load_bit);
        int n;
        int nrise;
        int lat;
        logic fb;
        n = (size > W) ? W : size;
        nrise = (kind != 0) ? stop_after : n;
        bus_cs_n    = 1'b0;
        fake_data   = word;
        data_size   = SW'(size);
        fake_select = sel;
        load        = 1'b1;
        @(negedge sys_clk);
        load      = 1'b0;
        fake_data = W'($urandom);
        if (n == 0) begin
            check("zero_done", 32'(done), 32'd1);
            check("zero_aborted", 32'(aborted), 32'd0);
            check("zero_busy", 32'(busy), 32'd0);
            check("zero_out", 32'(bus_out), 32'(real_in));
            step();
            check("zero_done_clear", 32'(done), 32'd0);
            check("zero_out2", 32'(bus_out), 32'(real_in));
            return;
        end
        check("load_busy", 32'(busy), 32'd1);
        check("load_bits_left", 32'(bits_left), 32'(n));
        for (int i = 0; i < nrise; i++) begin
            bus_sck = 1'b0;
            for (int c = 0; c < HALF; c++) begin
                load = 1'b0;
                if (i == mid_load_bit && c == 2) begin
                    load        = 1'b1;
                    fake_data   = 9'h1FF;
                    data_size   = SW'(W);
                    fake_select = 1'b1;
                end
                step();
                check("no_early_done", 32'(done), 32'd0);
                if (!sel) check("passthrough", 32'(bus_out), 32'(real_in));
            end
            load = 1'b0;
            if (sel) check("fake_bit", 32'(bus_out), 32'(model_bit(word, i)));
            check("bits_left_track", 32'(bits_left), 32'(n - i));
            check("busy_active", 32'(busy), 32'd1);
            bus_sck = 1'b1;
            if (kind == 0 && i == nrise - 1) begin
                wait_done(sel, lat);
                check("done_latency", 32'(lat), 32'(LAT));
                check("end_aborted", 32'(aborted), 32'd0);
                check("end_busy", 32'(busy), 32'd0);
                check("end_bits_left", 32'(bits_left), 32'd0);
                check("end_out_real", 32'(bus_out), 32'(real_in));
            end else begin
                for (int c = 0; c < HALF; c++) begin
                    step();
                    check("no_early_done_hi", 32'(done), 32'd0);
                    if (!sel) check("passthrough_hi", 32'(bus_out), 32'(real_in));
                end
            end
        end
        if (kind != 0) begin
            bus_sck = 1'b0;
            for (int c = 0; c < HALF; c++) begin
                step();
                check("no_done_pre_stop", 32'(done), 32'd0);
            end
            check("bits_left_pre_stop", 32'(bits_left), 32'(n - stop_after));
            if (kind == 1) begin
                bus_cs_n = 1'b1;
                wait_done(sel, lat);
                check("abort_latency", 32'(lat), 32'(LAT));
                check("abort_flag", 32'(aborted), 32'd1);
                check("abort_bits_left", 32'(bits_left), 32'(n - stop_after));
                check("abort_out_real", 32'(bus_out), 32'(real_in));
                check("abort_busy", 32'(busy), 32'd0);
            end else begin
                fb = model_bit(word, stop_after);
                if (sel) check("pre_reset_bit", 32'(bus_out), 32'(fb));
                real_in = ~fb;
                #2;
                rst_n = 1'b0;
                #1;
                check("reset_out_real", 32'(bus_out), 32'(real_in));
                check("reset_busy", 32'(busy), 32'd0);
                check("reset_done", 32'(done), 32'd0);
                bus_cs_n = 1'b1;
                for (int c = 0; c < 4; c++) begin
                    step();
                    check("reset_no_done", 32'(done), 32'd0);
                end
                rst_n = 1'b1;
            end
        end
        bus_sck = 1'b0;
        step();
        check("done_one_cycle", 32'(done), 32'd0);
        check("aborted_with_done", 32'(aborted), 32'd0);
        bus_cs_n = 1'b0;
        for (int c = 0; c < 2 * HALF; c++) begin
            step();
            check("idle_no_done", 32'(done), 32'd0);
            check("idle_out_real", 32'(bus_out), 32'(real_in));
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge sys_clk);
        real_in = 1'b1;
        #1;
        check("rst_out_hi", 32'(bus_out), 32'd1);
        real_in = 1'b0;
        #1;
        check("rst_out_lo", 32'(bus_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_bits_left", 32'(bits_left), 32'd0);
        @(negedge sys_clk);
        rst_n    = 1'b1;
        bus_cs_n = 1'b0;
        repeat (4) step();

        // Fake byte 0x24 from 9'h048
        run_transfer(9'h048, 8, 1'b1, 0, 0, -1);
        // Passthrough, 3 bits
        run_transfer(W'($urandom), 3, 1'b0, 0, 0, -1);
        // CS abort after 4 rises of a 9-bit transfer
        run_transfer(9'h0B6, 9, 1'b1, 1, 4, -1);
        // Zero size and oversize
        run_transfer(9'h1FF, 0, 1'b1, 0, 0, -1);
        run_transfer(9'h135, 15, 1'b1, 0, 0, -1);
        // Load while busy is ignored
        run_transfer(9'h0A5, 9, 1'b1, 0, 0, 2);
        // Reset after 3 bits, then a fresh transfer
        run_transfer(9'h0F0, 9, 1'b1, 2, 3, -1);
        repeat (4) step();
        run_transfer(9'h153, 5, 1'b1, 0, 0, -1);
        // Randomized transfers
        for (int k = 0; k < 6; k++) begin
            run_transfer(W'($urandom), $urandom_range(0, 15), 1'($urandom_range(0, 1)), 0, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mitm_bus_driver
